// File: rtl/branch_predictor.sv
// ---------------------------------------------------------------------------
// branch_predictor
//   Direction predictor built from a table of 2-bit saturating counters.
//   The FD-stage lookup is combinational. The X-stage resolved outcome
//   trains the counter indexed by pc[IDX+1:2]. Branch and mispredict
//   counts are kept for CSR readout.
//
//   Optional feature macro: BPRED_TAG_EN
//     defined   : each entry also holds a valid bit and a tag. A lookup miss
//                 predicts not-taken. An update that misses allocates the
//                 entry (counter 10 if taken, 01 if not).
//     undefined : there is no tag storage, so aliasing PCs share a counter.
//
// Ports
//   clk, rst          clock and synchronous active-high reset
//   guess_pc/valid    FD lookup request
//   guess_taken       predicted direction (combinational)
//   check_pc/valid    X-stage training request
//   check_taken       resolved direction
//   check_mispredict  core mispredict flag (statistics only)
//   br_count          resolved-branch count (registered, wraps)
//   mispredict_count  mispredict count (registered, wraps)
// ---------------------------------------------------------------------------
module branch_predictor #(
    parameter int LINES    = 32,
    parameter int PC_WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PC_WIDTH-1:0] guess_pc,
    input  logic                guess_valid,
    output logic                guess_taken,
    input  logic [PC_WIDTH-1:0] check_pc,
    input  logic                check_valid,
    input  logic                check_taken,
    input  logic                check_mispredict,
    output logic [31:0]         br_count,
    output logic [31:0]         mispredict_count
);
    localparam int IDX  = $clog2(LINES);
    localparam int TAGW = PC_WIDTH - IDX - 2;

    logic [1:0]     ctr [LINES];
    logic [IDX-1:0] guess_idx;
    logic [IDX-1:0] check_idx;
    logic           guess_hit;
    logic           check_hit;
    logic [1:0]     ctr_next;

    assign guess_idx = guess_pc[IDX+1:2];
    assign check_idx = check_pc[IDX+1:2];

`ifdef BPRED_TAG_EN
    logic [LINES-1:0] vld;
    logic [TAGW-1:0]  tag_mem [LINES];

    assign guess_hit = vld[guess_idx] && (tag_mem[guess_idx] == guess_pc[PC_WIDTH-1:IDX+2]);
    assign check_hit = vld[check_idx] && (tag_mem[check_idx] == check_pc[PC_WIDTH-1:IDX+2]);

    logic unused_pc;
    assign unused_pc = ^{guess_pc[1:0], check_pc[1:0]};
`else
    assign guess_hit = 1'b1;
    assign check_hit = 1'b1;

    // Tag bits only matter in the tagged build.
    logic unused_pc;
    assign unused_pc = ^{guess_pc[PC_WIDTH-1:IDX+2], guess_pc[1:0],
                         check_pc[PC_WIDTH-1:IDX+2], check_pc[1:0]};
`endif

    // The lookup reads the registered table, so a same-cycle update to the
    // same index is not bypassed.
    assign guess_taken = guess_valid & guess_hit & ctr[guess_idx][1];

    // Saturating step for a hit. A miss (tagged build only) reinitialises the
    // counter to the weak state for the resolved direction.
    always_comb begin
        ctr_next = ctr[check_idx];
        if (!check_hit) begin
            ctr_next = check_taken ? 2'b10 : 2'b01;
        end else if (check_taken) begin
            if (ctr[check_idx] != 2'b11) ctr_next = ctr[check_idx] + 2'b01;
        end else begin
            if (ctr[check_idx] != 2'b00) ctr_next = ctr[check_idx] - 2'b01;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LINES; i++) ctr[i] <= 2'b01;
`ifdef BPRED_TAG_EN
            vld <= '0;
`endif
            br_count         <= '0;
            mispredict_count <= '0;
        end else if (check_valid) begin
            ctr[check_idx] <= ctr_next;
`ifdef BPRED_TAG_EN
            vld[check_idx]     <= 1'b1;
            tag_mem[check_idx] <= check_pc[PC_WIDTH-1:IDX+2];
`endif
            br_count <= br_count + 32'd1;
            if (check_mispredict) mispredict_count <= mispredict_count + 32'd1;
        end
    end
endmodule

// File: tb/tb_branch_predictor.sv
// ---------------------------------------------------------------------------
// tb_branch_predictor
//   Directed bench for branch_predictor (LINES=32, PC_WIDTH=32). Expected
//   values are queued when stimulus is driven and popped at each sample point.
//   The aliasing expectation depends on BPRED_TAG_EN.
// ---------------------------------------------------------------------------
module tb_branch_predictor;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] guess_pc;
    logic        guess_valid;
    logic        guess_taken;
    logic [31:0] check_pc;
    logic        check_valid;
    logic        check_taken;
    logic        check_mispredict;
    logic [31:0] br_count;
    logic [31:0] mispredict_count;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q [$];
    string       tag_q [$];

    branch_predictor #(.LINES(32), .PC_WIDTH(32)) dut (
        .clk              (clk),
        .rst              (rst),
        .guess_pc         (guess_pc),
        .guess_valid      (guess_valid),
        .guess_taken      (guess_taken),
        .check_pc         (check_pc),
        .check_valid      (check_valid),
        .check_taken      (check_taken),
        .check_mispredict (check_mispredict),
        .br_count         (br_count),
        .mispredict_count (mispredict_count)
    );

    always #5 clk = ~clk;

    task automatic push(input string tag, input logic [31:0] val);
        tag_q.push_back(tag);
        exp_q.push_back(val);
    endtask

    task automatic chk(input logic [31:0] obs);
        logic [31:0] e;
        string       t;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty: observed %0h, required an expected entry", obs);
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            assert (obs === e) else begin
                errors++;
                $error("FAIL %s: observed %0h required %0h", t, obs, e);
            end
        end
    endtask

    // Drive one update for a full cycle; returns #1 after the edge.
    task automatic upd(input logic [31:0] pc, input logic t, input logic m);
        check_pc = pc; check_taken = t; check_mispredict = m; check_valid = 1'b1;
        @(posedge clk); #1;
        check_valid = 1'b0; check_mispredict = 1'b0;
    endtask

    // Combinational lookup between edges.
    task automatic look(input string tag, input logic [31:0] pc, input logic gv,
                        input logic e);
        guess_pc = pc; guess_valid = gv;
        push(tag, {31'd0, e});
        #1;
        chk({31'd0, guess_taken});
        guess_valid = 1'b0;
    endtask

    task automatic chk_ctr(input string tag, input int idx, input logic [1:0] e);
        push(tag, {30'd0, e});
        chk({30'd0, dut.ctr[idx]});
    endtask

    task automatic chk_stats(input string tag, input logic [31:0] eb, input logic [31:0] em);
        push({tag, "_br"}, eb);
        chk(br_count);
        push({tag, "_mis"}, em);
        chk(mispredict_count);
    endtask

    initial begin
        rst = 1'b1;
        guess_pc = '0; guess_valid = 1'b0;
        // An update held during reset must be discarded.
        check_pc = 32'h1000; check_valid = 1'b1; check_taken = 1'b1; check_mispredict = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0; check_valid = 1'b0; check_mispredict = 1'b0;

        // Reset state
        look("reset_lookup", 32'h1000, 1'b1, 1'b0);
        chk_ctr("reset_ctr", 0, 2'b01);
        chk_stats("reset", 32'd0, 32'd0);

        // Saturation up, then back-to-back decrements from 11
        repeat (3) upd(32'h1000, 1'b1, 1'b0);
        look("sat_up_lookup", 32'h1000, 1'b1, 1'b1);
        chk_ctr("sat_up_ctr", 0, 2'b11);
        look("guess_valid_low", 32'h1000, 1'b0, 1'b0);
        upd(32'h1000, 1'b0, 1'b0);
        upd(32'h1000, 1'b0, 1'b0);
        chk_ctr("dec_twice_ctr", 0, 2'b01);
        look("dec_twice_lookup", 32'h1000, 1'b1, 1'b0);

        // Saturation down at index 1
        repeat (5) upd(32'h2004, 1'b0, 1'b0);
        chk_ctr("sat_down_ctr", 1, 2'b00);
        upd(32'h2004, 1'b1, 1'b0);
        chk_ctr("sat_down_inc_ctr", 1, 2'b01);
        look("sat_down_lookup", 32'h2004, 1'b1, 1'b0);

        // Same-cycle collision: index 0 is at 01
        guess_pc = 32'h1000; guess_valid = 1'b1;
        check_pc = 32'h1000; check_taken = 1'b1; check_valid = 1'b1;
        push("collide_pre_update", 32'd0);
        #1;
        chk({31'd0, guess_taken});
        @(posedge clk); #1;
        // Next cycle sees 10 while a second taken update is in flight.
        push("collide_next_cycle", 32'd1);
        chk({31'd0, guess_taken});
        chk_ctr("collide_ctr10", 0, 2'b10);
        @(posedge clk); #1;
        check_valid = 1'b0; guess_valid = 1'b0;
        chk_ctr("collide_ctr11", 0, 2'b11);

        // Aliasing: 0x1000 and 0x1080 share index 0
        upd(32'h1000, 1'b1, 1'b0);
        upd(32'h1000, 1'b1, 1'b0);
`ifdef BPRED_TAG_EN
        look("alias_lookup", 32'h1080, 1'b1, 1'b0);
        upd(32'h1080, 1'b0, 1'b0);   // evicts 0x1000, allocates at 01
        look("alias_evict", 32'h1000, 1'b1, 1'b0);
        chk_ctr("alias_alloc_ctr", 0, 2'b01);
`else
        look("alias_lookup", 32'h1080, 1'b1, 1'b1);
        upd(32'h1080, 1'b0, 1'b0);   // shared counter 11 -> 10
        look("alias_shared", 32'h1000, 1'b1, 1'b1);
        chk_ctr("alias_shared_ctr", 0, 2'b10);
`endif

        // Reset mid-operation drops all training and statistics
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        look("midreset_lookup", 32'h1000, 1'b1, 1'b0);
        chk_ctr("midreset_ctr", 1, 2'b01);
        chk_stats("midreset", 32'd0, 32'd0);

        // Statistics: 10 updates, 3 mispredicted, plus an ignored mispredict
        for (int i = 0; i < 10; i++)
            upd(32'h4000 + 32'(i * 4), i[0], (i == 1) || (i == 4) || (i == 7));
        check_mispredict = 1'b1;
        @(posedge clk); #1;
        check_mispredict = 1'b0;
        chk_stats("stats", 32'd10, 32'd3);

        // Wrap of br_count
        force dut.br_count = 32'hFFFF_FFFF;
        #1;
        release dut.br_count;
        push("wrap_preload", 32'hFFFF_FFFF);
        chk(br_count);
        upd(32'h5000, 1'b1, 1'b0);
        chk_stats("wrap", 32'd0, 32'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/branch_predictor.md
# branch_predictor

Direction predictor that supplies `pred_taken` to the core's control logic and receives branch outcomes back from it. A fetch/decode-stage lookup returns a taken/not-taken guess in the same cycle. An execute-stage update trains a table of 2-bit saturating counters with the resolved direction. It also keeps branch and mispredict statistics for CSR readout.

## Interface
Parameters:
- `LINES`, default 32: table entries; must be a power of two ≥ 2. `IDX = log2(LINES)`.
- `PC_WIDTH`, default 32: PC width.

Ports:
- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `guess_pc`  in  PC_WIDTH  PC of the instruction in FD.
- `guess_valid`  in  1  FD instruction is a conditional branch.
- `guess_taken`  out  1  predicted direction; combinational; feeds the core's `pred_taken`.
- `check_pc`  in  PC_WIDTH  PC of the branch in X.
- `check_valid`  in  1  X instruction is a conditional branch; train this cycle.
- `check_taken`  in  1  resolved direction (core `br_taken`).
- `check_mispredict`  in  1  core `mispredict` for the X branch; used for statistics only.
- `br_count`  out  32  resolved-branch counter.
- `mispredict_count`  out  32  mispredict counter.

## Operation
- Index is `pc[IDX+1:2]`; `pc[1:0]` is ignored. Tag is `pc[PC_WIDTH-1:IDX+2]`.
- Each entry holds a 2-bit counter with these encodings:
  - 00: strong not-taken.
  - 01: weak not-taken.
  - 10: weak taken.
  - 11: strong taken.
- Prediction is `counter[1]`.
- Lookup:
  - `guess_taken = guess_valid & hit & ctr[idx(guess_pc)][1]`.
  - `guess_valid = 0` gives `guess_taken = 0`.
- Update, when `check_valid` is high on a hit:
  - taken: counter increments, saturating at 11.
  - not-taken: counter decrements, saturating at 00.
- No update when `check_valid` is low, whatever the other check inputs are.
- Statistics:
  - `br_count` increments when `check_valid` is high.
  - `mispredict_count` increments when `check_valid & check_mispredict` is high.
  - Both counters wrap from 0xFFFF_FFFF to 0.
  - `check_mispredict` while `check_valid` is low is ignored.
- Reset:
  - All counters go to 01.
  - All valid bits clear (tagged build).
  - `br_count` and `mispredict_count` go to 0.
  - `guess_taken` reads 0 in the cycle after reset.
  - An update presented during a reset cycle is discarded.
  - Reset mid-operation drops all training; no partial state survives.

## Timing
- Lookup: zero latency, combinational from `guess_pc`/`guess_valid` and the table registers.
- Update: written at the rising edge ending the cycle in which `check_valid` is high; visible to lookups from the next cycle.
- Same-index lookup and update in one cycle: `guess_taken` reflects the pre-update value; there is no bypass.
- Back-to-back updates to one index on consecutive cycles each apply in order. For example, 11 followed by not-taken, not-taken ends at 01.
- Statistics outputs are registered and reflect events up to the previous edge.
- No handshake: the block never stalls the pipeline. One lookup and one update are accepted every cycle.

## Configuration
- Feature macro: `BPRED_TAG_EN`.
- Defined:
  - Each entry also stores a valid bit and a tag.
  - `hit = valid[idx] & (tag[idx] == tag(pc))`.
  - A lookup miss predicts not-taken.
  - An update on a miss allocates the entry: valid is set, the tag is written, and the counter becomes 10 if taken, else 01.
  - Aliasing branches evict each other.
- Undefined:
  - No tag or valid storage; `hit` is constant 1.
  - Aliasing branches share a counter.
  - An update on any index trains that counter.

## Test plan
- Reset then lookup of any PC (e.g. 0x0000_1000, `guess_valid=1`) -> `guess_taken=0`, `br_count=0`, `mispredict_count=0`.
- Saturation up:
  - Stimulus: three taken updates to 0x1000, then one lookup.
  - Required: `guess_taken=1`, counter at 11.
  - Then two not-taken updates -> counter 01, `guess_taken=0`.
- Saturation down: five not-taken updates to 0x2004 -> counter stays 00; one taken update -> 01, `guess_taken` still 0.
- Same-cycle collision:
  - Stimulus: counter at 01; update taken and lookup of the same PC in one cycle.
  - Required: `guess_taken=0` that cycle; with a second taken update, `guess_taken=1` the following cycle (counter 10).
- Aliasing, LINES=32:
  - Stimulus: PCs 0x0000_1000 and 0x0000_1080 share index 0; train 0x1000 taken twice, then look up 0x1080.
  - Required with `BPRED_TAG_EN`: `guess_taken=0` (miss).
  - Required without: `guess_taken=1`.
- Statistics:
  - Stimulus: 10 updates with `check_mispredict` high on 3 of them; one cycle with `check_valid=0` and `check_mispredict=1`.
  - Required: `br_count=10`, `mispredict_count=3`.
  - Preload near wrap (force 0xFFFF_FFFF) plus one update -> `br_count=0`.
